// File: rtl/jericalla_pkg.sv
// Shared constants for the Jericalla instruction sequencer: instruction word
// layout, ALU op encodings and sequencer state codes.
package jericalla_pkg;

   localparam int unsigned INSTR_W = 17;

   // Instruction word field positions
   localparam int unsigned RAM_ADDR_MSB = 16;
   localparam int unsigned RAM_ADDR_LSB = 13;
   localparam int unsigned OP_MSB       = 12;
   localparam int unsigned OP_LSB       = 9;
   localparam int unsigned DIR1_MSB     = 8;
   localparam int unsigned DIR1_LSB     = 5;
   localparam int unsigned DIR2_MSB     = 4;
   localparam int unsigned DIR2_LSB     = 1;
   localparam int unsigned EN_BIT       = 0;

   // Datapath ALU op encodings
   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_PASA  = 4'b0001;
   localparam logic [3:0] OP_SUMA  = 4'b0010;
   localparam logic [3:0] OP_RESTA = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_OR    = 4'b0101;

   // Sequencer states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_WRITE = 2'd1;
   localparam state_t ST_READ  = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Read-back word: keep only the RAM address of a write word, en=0
   function automatic logic [INSTR_W-1:0] read_word(input logic [INSTR_W-1:0] w);
      read_word = '0;
      read_word[RAM_ADDR_MSB:RAM_ADDR_LSB] = w[RAM_ADDR_MSB:RAM_ADDR_LSB];
   endfunction

endpackage

// File: rtl/jericalla_prog_mem.sv
// Program store for the sequencer: DEPTH x WIDTH register file with
// synchronous write and asynchronous read. Contents are not reset.
module jericalla_prog_mem #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 17
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [3:0]       waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [3:0]       raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Program entry write
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jericalla_secuenciador.sv
// Jericalla instruction sequencer. Runs a loaded program entry by entry, each
// as a write phase (en=1, WR_CYCLES cycles) followed by a one-cycle read-back
// phase (en=0) at the same RAM address, capturing the returned data and zflag.
// Optional feature macro: JERICALLA_HALT_ON_ZERO_EN (halt-marker in bit 0 plus
// a 'halted' output).
module jericalla_secuenciador
   import jericalla_pkg::*;
#(
   parameter int unsigned PROG_DEPTH = 16,
   parameter int unsigned WR_CYCLES  = 1,
   parameter int unsigned DATA_W     = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_we,
   input  logic [3:0]         load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic [4:0]         prog_len,
   input  logic               start,
   output logic [INSTR_W-1:0] instruccion,
   input  logic [DATA_W-1:0]  salida_in,
   input  logic               zflag_in,
   output logic [DATA_W-1:0]  result,
   output logic               result_zf,
   output logic [3:0]         result_idx,
   output logic               result_valid,
   output logic               busy,
   output logic               done
`ifdef JERICALLA_HALT_ON_ZERO_EN
  ,output logic               halted
`endif
);

   // Bit 0 only needs storing when it carries the halt marker
`ifdef JERICALLA_HALT_ON_ZERO_EN
   localparam int unsigned MEM_W = INSTR_W;
`else
   localparam int unsigned MEM_W = INSTR_W - 1;
`endif

   state_t              state_q;
   logic [3:0]          pc_q;
   logic [3:0]          wr_cnt_q;
   logic [4:0]          len_q;
   logic                zf_q;
   logic [DATA_W-1:0]   result_q;
   logic                result_zf_q;
   logic [3:0]          result_idx_q;
   logic                result_valid_q;

   logic [4:0]          len_eff;
   logic                mem_we;
   logic [MEM_W-1:0]    mem_wdata;
   logic [MEM_W-1:0]    mem_rdata;
   logic [INSTR_W-1:0]  wr_word;
   logic                last_wr;
   logic                last_entry;
   logic                halt_hit;

   assign len_eff    = (prog_len > 5'(PROG_DEPTH)) ? 5'(PROG_DEPTH) : prog_len;
   assign mem_we     = load_we && (state_q == ST_IDLE) && ({1'b0, load_addr} < 5'(PROG_DEPTH));
   assign wr_word    = {mem_rdata[MEM_W-1 -: INSTR_W-1], 1'b1};
   assign last_wr    = (wr_cnt_q == 4'(WR_CYCLES - 1));
   assign last_entry = ({1'b0, pc_q} == (len_q - 5'd1));

`ifdef JERICALLA_HALT_ON_ZERO_EN
   logic halt_q;
   logic halted_q;

   assign mem_wdata = load_data;
   assign halt_hit  = halt_q;
   assign halted    = halted_q;

   // Halt marker: judged on the last write cycle, reported with the halting done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt_q   <= 1'b0;
         halted_q <= 1'b0;
      end else if ((state_q == ST_IDLE) && start) begin
         halt_q   <= 1'b0;
         halted_q <= 1'b0;
      end else if ((state_q == ST_WRITE) && last_wr) begin
         halt_q <= zflag_in & mem_rdata[EN_BIT];
      end else if ((state_q == ST_READ) && halt_q) begin
         halted_q <= 1'b1;
      end
   end
`else
   logic unused_en_bit;

   assign mem_wdata     = load_data[INSTR_W-1:1];
   assign halt_hit      = 1'b0;
   assign unused_en_bit = load_data[EN_BIT];
`endif

   jericalla_prog_mem #(
      .DEPTH (PROG_DEPTH),
      .WIDTH (MEM_W)
   ) u_prog_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (load_addr),
      .wdata_i (mem_wdata),
      .raddr_i (pc_q),
      .rdata_o (mem_rdata)
   );

   // Sequencer state, program counter and read-back capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         pc_q           <= '0;
         wr_cnt_q       <= '0;
         len_q          <= '0;
         zf_q           <= 1'b0;
         result_q       <= '0;
         result_zf_q    <= 1'b0;
         result_idx_q   <= '0;
         result_valid_q <= 1'b0;
      end else begin
         result_valid_q <= (state_q == ST_READ);
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  pc_q     <= '0;
                  wr_cnt_q <= '0;
                  len_q    <= len_eff;
                  state_q  <= (len_eff == 5'd0) ? ST_DONE : ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (last_wr) begin
                  zf_q     <= zflag_in;
                  wr_cnt_q <= '0;
                  state_q  <= ST_READ;
               end else begin
                  wr_cnt_q <= wr_cnt_q + 4'd1;
               end
            end
            ST_READ: begin
               result_q     <= salida_in;
               result_zf_q  <= zf_q;
               result_idx_q <= pc_q;
               if (last_entry || halt_hit) begin
                  state_q <= ST_DONE;
               end else begin
                  pc_q    <= pc_q + 4'd1;
                  state_q <= ST_WRITE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Instruction word is decoded from state so en drops the instant reset hits
   always_comb begin
      instruccion = '0;
      case (state_q)
         ST_WRITE: instruccion = wr_word;
         ST_READ:  instruccion = read_word(wr_word);
         default:  instruccion = '0;
      endcase
   end

   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign result       = result_q;
   assign result_zf    = result_zf_q;
   assign result_idx   = result_idx_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_jericalla_secuenciador.sv
// Bench for jericalla_secuenciador: three instances (WR_CYCLES 1, 3, 4) share
// all inputs. A run-level model turns each accepted start into per-cycle
// expected outputs; a compare process checks every cycle, and directed
// literal checks pin the model on the hand-computed cases.
module tb_jericalla_secuenciador;
   import jericalla_pkg::*;

   localparam int MAXC = 2048;
   localparam int NDUT = 3;

   function automatic int wr_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
   endfunction

   logic        clk = 1'b0;
   logic        rst_n, load_we, start, zflag_in;
   logic [3:0]  load_addr;
   logic [16:0] load_data;
   logic [4:0]  prog_len;
   logic [31:0] salida_in;

   logic [16:0] instr_w [NDUT];
   logic [31:0] res_w   [NDUT];
   logic [3:0]  idx_w   [NDUT];
   logic        zf_w [NDUT], rv_w [NDUT], busy_w [NDUT], done_w [NDUT];
`ifdef JERICALLA_HALT_ON_ZERO_EN
   logic        halted_w [NDUT];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      jericalla_secuenciador #(
         .PROG_DEPTH (16),
         .WR_CYCLES  (wr_of(g)),
         .DATA_W     (32)
      ) dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .load_we      (load_we),
         .load_addr    (load_addr),
         .load_data    (load_data),
         .prog_len     (prog_len),
         .start        (start),
         .instruccion  (instr_w[g]),
         .salida_in    (salida_in),
         .zflag_in     (zflag_in),
         .result       (res_w[g]),
         .result_zf    (zf_w[g]),
         .result_idx   (idx_w[g]),
         .result_valid (rv_w[g]),
         .busy         (busy_w[g]),
         .done         (done_w[g])
`ifdef JERICALLA_HALT_ON_ZERO_EN
        ,.halted       (halted_w[g])
`endif
      );
   end

   int nchk = 0;
   int nerr = 0;
   int pe = 0;          // index of the current clock interval
   int sovr = 0;        // 1: datapath stub returns 42
   int zmode = 0;       // 0 pattern, 1 always 1, 2 one-hot at zhot, 3 always 0
   int zhot = 0;

   // Expected per-interval outputs, per instance
   bit [16:0]   e_instr [NDUT][MAXC];
   bit          e_busy  [NDUT][MAXC];
   bit          e_done  [NDUT][MAXC];
   bit          e_rv    [NDUT][MAXC];
   bit [31:0]   e_res   [NDUT][MAXC];
   bit          e_zf    [NDUT][MAXC];
   bit [3:0]    e_idx   [NDUT][MAXC];
   bit          e_halt  [NDUT][MAXC];
   logic [16:0] mprog   [NDUT][16];
   int          last_done [NDUT];

   function automatic logic [31:0] sval(input int p);
      return (sovr != 0) ? 32'd42 : (32'h1000_0000 ^ (32'(p) * 32'h0000_9E37));
   endfunction

   function automatic logic zval(input int p);
      case (zmode)
         1:       return 1'b1;
         2:       return (p == zhot);
         3:       return 1'b0;
         default: return ((p % 3) == 0);
      endcase
   endfunction

   function automatic logic [16:0] tbl_word(input int i);
      logic [3:0] op;
      op = (i % 2 == 1) ? OP_SUMA : OP_RESTA;
      return {4'(i + 3), op, 4'(15 - i), 4'(i * 5), 1'b0};
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, k, pe, act, exp);
      end
   endtask

   // ---------------- model ----------------
   task automatic m_hold(input int k, input int t, input logic [31:0] r, input bit z,
                         input logic [3:0] i);
      for (int p = t; p < MAXC; p++) begin
         e_res[k][p] = r;
         e_zf[k][p]  = z;
         e_idx[k][p] = i;
      end
   endtask

   task automatic m_halt(input int k, input int t, input bit v);
      for (int p = t; p < MAXC; p++) e_halt[k][p] = v;
   endtask

   task automatic m_reset(input int t);
      for (int k = 0; k < NDUT; k++) begin
         for (int p = t; p < MAXC; p++) begin
            e_instr[k][p] = '0; e_busy[k][p] = 0; e_done[k][p] = 0; e_rv[k][p] = 0;
            e_res[k][p] = '0; e_zf[k][p] = 0; e_idx[k][p] = '0; e_halt[k][p] = 0;
         end
         last_done[k] = t;
      end
   endtask

   task automatic m_load(input int t, input int a, input logic [16:0] d);
      for (int k = 0; k < NDUT; k++)
         if (t > last_done[k]) mprog[k][a] = d;
   endtask

   task automatic m_start(input int s, input int len);
      for (int k = 0; k < NDUT; k++) begin
         if (s > last_done[k]) begin
            int n, w, t;
            bit z, hlt;
            n = (len > 16) ? 16 : len;
            w = wr_of(k);
            t = s + 1;
            z = 0;
            hlt = 0;
            m_halt(k, t, 0);
            for (int i = 0; i < n && !hlt; i++) begin
               for (int j = 0; j < w; j++) begin
                  e_instr[k][t] = {mprog[k][i][16:1], 1'b1};
                  e_busy[k][t]  = 1;
                  z = zval(t);
                  t++;
               end
               e_instr[k][t] = {mprog[k][i][16:13], 13'b0};
               e_busy[k][t]  = 1;
               e_rv[k][t+1]  = 1;
               m_hold(k, t + 1, sval(t), z, 4'(i));
               t++;
`ifdef JERICALLA_HALT_ON_ZERO_EN
               if (mprog[k][i][0] && z) hlt = 1;
`endif
            end
            e_busy[k][t] = 1;
            e_done[k][t] = 1;
            if (hlt) m_halt(k, t, 1);
            last_done[k] = t;
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   always @(posedge clk) pe <= pe + 1;

   // Datapath stub: data and zero flag as a function of the cycle
   always @(negedge clk) begin
      salida_in = sval(pe);
      zflag_in  = zval(pe);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int a, input logic [16:0] d);
      load_we = 1'b1; load_addr = 4'(a); load_data = d;
      m_load(pe, a, d);
      tick(1);
      load_we = 1'b0;
   endtask

   task automatic do_start(input int len, output int s);
      s = pe;
      prog_len = 5'(len); start = 1'b1;
      m_start(pe, len);
      tick(1);
      start = 1'b0;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (pe < MAXC) begin
         for (int k = 0; k < NDUT; k++) begin
            chk("instruccion",  k, 32'(instr_w[k]), 32'(e_instr[k][pe]));
            chk("busy",         k, 32'(busy_w[k]),  32'(e_busy[k][pe]));
            chk("done",         k, 32'(done_w[k]),  32'(e_done[k][pe]));
            chk("result_valid", k, 32'(rv_w[k]),    32'(e_rv[k][pe]));
            chk("result",       k, res_w[k],        e_res[k][pe]);
            chk("result_zf",    k, 32'(zf_w[k]),    32'(e_zf[k][pe]));
            chk("result_idx",   k, 32'(idx_w[k]),   32'(e_idx[k][pe]));
`ifdef JERICALLA_HALT_ON_ZERO_EN
            chk("halted",       k, 32'(halted_w[k]), 32'(e_halt[k][pe]));
`endif
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int s, s2, cnt;
      rst_n = 1'b0; load_we = 1'b0; start = 1'b0; load_addr = '0; load_data = '0;
      prog_len = '0; salida_in = '0; zflag_in = 1'b0;
      for (int k = 0; k < NDUT; k++) last_done[k] = -1;

      // Reset state
      tick(1);
      chk("rst_instr",  0, 32'(instr_w[0]), 32'h0);
      chk("rst_busy",   0, 32'(busy_w[0]),  32'h0);
      chk("rst_result", 0, res_w[0],        32'h0);
      chk("rst_valid",  0, 32'(rv_w[0]),    32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      for (int i = 0; i < 16; i++) do_load(i, (i == 0) ? 17'h0648D : tbl_word(i));
      tick(1);

      // Single entry, stub returns 42, zflag 0
      zmode = 3; sovr = 1;
      do_start(1, s);
      chk("single_wr_word", 0, 32'(instr_w[0]), 32'h0648D);
      tick(1);
      chk("single_rd_word", 0, 32'(instr_w[0]), 32'h06000);
      tick(1);
      chk("single_done",   0, 32'(done_w[0]), 32'h1);
      chk("single_valid",  0, 32'(rv_w[0]),   32'h1);
      chk("single_result", 0, res_w[0],       32'd42);
      chk("single_idx",    0, 32'(idx_w[0]),  32'h0);
      tick(10);
      sovr = 0;

      // Three entries: pulses at +3, +5, +7, done at +7
      do_start(3, s);
      tick(2);
      chk("multi_v0", 0, {27'b0, rv_w[0], idx_w[0]}, 32'h10);
      tick(2);
      chk("multi_v1", 0, {27'b0, rv_w[0], idx_w[0]}, 32'h11);
      tick(2);
      chk("multi_v2", 0, {27'b0, rv_w[0], idx_w[0]}, 32'h12);
      chk("multi_done", 0, 32'(done_w[0]), 32'h1);
      tick(15);

      // prog_len=0: done in the very next cycle
      do_start(0, s);
      chk("len0_done", 0, 32'(done_w[0]), 32'h1);
      chk("len0_en",   2, 32'(instr_w[2]), 32'h0);
      tick(3);

      // load_we and start while busy are both ignored
      zmode = 0;
      do_start(3, s);
      tick(1);
      do_load(0, 17'h1FFFF);
      do_start(1, s2);
      tick(15);
      zmode = 3;
      do_start(1, s);
      chk("prog_unchanged", 0, 32'(instr_w[0]), 32'h0648D);
      tick(8);

      // zflag only on the 4th write cycle of entry 0
      zmode = 2; zhot = pe + 4;
      do_start(1, s);
      tick(3);
      chk("wr4_en_4th", 2, 32'(instr_w[2][0]), 32'h1);
      tick(1);
      chk("wr4_en_read", 2, 32'(instr_w[2][0]), 32'h0);
      tick(2);
      chk("wr4_zf", 2, 32'(zf_w[2]), 32'h1);
      chk("wr3_zf", 1, 32'(zf_w[1]), 32'h0);
      tick(5);

      // prog_len above depth is clamped to 16 entries
      zmode = 3;
      do_start(20, s);
      tick(32);
      chk("clamp_done", 0, 32'(done_w[0]), 32'h1);
      chk("clamp_idx",  0, 32'(idx_w[0]),  32'd15);
      tick(55);

      // Asynchronous reset in the middle of a write phase
      zmode = 0;
      do_start(2, s);
      tick(1);
      rst_n = 1'b0;
      m_reset(pe);
      #1;
      chk("midrst_instr", 1, 32'(instr_w[1]), 32'h0);
      chk("midrst_busy",  1, 32'(busy_w[1]),  32'h0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      zmode = 3;
      do_start(1, s);
      chk("after_rst_entry0", 1, 32'(instr_w[1]), 32'h0648D);
      tick(10);

`ifdef JERICALLA_HALT_ON_ZERO_EN
      // Entry 1 marked, zflag high: stop after entry 1's read-back
      zmode = 1;
      do_load(0, 17'h0648C);
      do_load(1, tbl_word(1) | 17'h1);
      do_load(2, tbl_word(2));
      do_load(3, tbl_word(3));
      do_start(4, s);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (rv_w[0]) cnt++;
         tick(1);
      end
      chk("halt_pulses", 0, 32'(cnt), 32'd2);
      chk("halt_flag",   0, 32'(halted_w[0]), 32'h1);
      zmode = 3;
      do_start(0, s);
      chk("halt_clear",  0, 32'(halted_w[0]), 32'h0);
      tick(3);
`else
      cnt = 0;
`endif

      tick(5);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
